dcache_ctrl: RTL

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache, 16 x 256-bit lines, fixed-latency burst memory port.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl (
   input  logic         clk,
   input  logic         rst,
   input  logic         cpu_en,
   input  logic         cpu_write,
   input  logic [15:0]  cpu_addr,
   input  logic [31:0]  cpu_wdata,
   output logic [31:0]  cpu_rdata,
   output logic         cpu_stall,
   output logic         ram_en,
   output logic         ram_write,
   output logic [10:0]  ram_addr,
   output logic [255:0] data_to_ram,
   input  logic [255:0] block_in,
   input  logic         ram_rdy,
   output logic [31:0]  hit_count,
   output logic [31:0]  miss_count
);

   typedef enum logic [1:0] {IDLE, WRITEBACK, GAP, FILL} state_t;

   state_t       state_q;
   logic [255:0] data_q [16];
   logic [6:0]   tag_q  [16];
   logic [15:0]  valid_q;
   logic [15:0]  dirty_q;
   logic [3:0]   burst_q;
   logic [3:0]   burst_d;

   logic [6:0]   tag;
   logic [3:0]   idx;
   logic [2:0]   off;
   logic         hit;
   logic         miss;
   logic         xfer_done;
   logic         unused_addr_bits;

   assign tag = cpu_addr[15:9];
   assign idx = cpu_addr[8:5];
   assign off = cpu_addr[4:2];
   assign unused_addr_bits = ^cpu_addr[1:0];

   assign hit  = (state_q == IDLE) & cpu_en & valid_q[idx] & (tag_q[idx] == tag);
   assign miss = (state_q == IDLE) & cpu_en & ~hit;

   // Burst counter holds the number of earlier consecutive ram_en cycles,
   // so a value of 8 means the current cycle is the 9th.
   assign xfer_done = ram_en & ram_rdy & (burst_q >= 4'd8);

   always_comb begin
      ram_en      = (state_q == WRITEBACK) | (state_q == FILL);
      ram_write   = (state_q == WRITEBACK);
      ram_addr    = (state_q == WRITEBACK) ? {tag_q[idx], idx} : cpu_addr[15:5];
      data_to_ram = data_q[idx];
      cpu_rdata   = data_q[idx][{off, 5'b0} +: 32];
      cpu_stall   = (state_q != IDLE) | miss;
      burst_d     = 4'd0;
      if (ram_en)
         burst_d = (burst_q == 4'hF) ? 4'hF : burst_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         burst_q <= '0;
      end else begin
         burst_q <= burst_d;
         unique case (state_q)
            IDLE: begin
               if (hit && cpu_write) begin
                  data_q[idx][{off, 5'b0} +: 32] <= cpu_wdata;
                  dirty_q[idx]                   <= 1'b1;
               end else if (miss) begin
                  state_q <= (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FILL;
               end
            end
            WRITEBACK: if (xfer_done) state_q <= GAP;
            GAP:       state_q <= FILL;
            FILL: begin
               if (xfer_done) begin
                  data_q[idx]  <= block_in;
                  tag_q[idx]   <= tag;
                  valid_q[idx] <= 1'b1;
                  dirty_q[idx] <= 1'b0;
                  state_q      <= IDLE;
               end
            end
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_q;
   logic [31:0] miss_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         if (hit)  hit_q  <= hit_q + 32'd1;
         if (miss) miss_q <= miss_q + 32'd1;
      end
   end

   assign hit_count  = hit_q;
   assign miss_count = miss_q;
`else
   assign hit_count  = 32'd0;
   assign miss_count = 32'd0;
`endif

endmodule
